// File: rtl/bram_fifo_pkg.sv
// Shared constants for the block-RAM FIFO controller.
package bram_fifo_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 3;

  // Read data from the RAM core appears this many clka cycles after the
  // address is sampled.
  localparam int unsigned RAM_RD_LAT = 1;

  // Number of RAM entries addressed by an addr_w-bit address.
  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/bram_fifo_ctrl.sv
// Streaming FIFO controller owning the single port of an 8x8 block RAM.
// Bytes enter on a valid/ready input, are written to the RAM, read back in
// order and presented through a one-entry output register.
module bram_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [ADDR_W:0]   occupancy,
  output logic              full,
  output logic              empty,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  ram_cnt_q, ram_cnt_d;
  logic              rd_pending_q, rd_pending_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic rd_issue;
  logic wr_fire;
  logic ram_full;

  // Port arbitration: a read is issued only when the output path is free,
  // and it takes the port ahead of any write. Depends on registered state
  // only, so out_ready and in_valid never reach in_ready.
  always_comb begin
    ram_full = (ram_cnt_q == CNT_W'(DEPTH));
    rd_issue = (ram_cnt_q != '0) && !rd_pending_q && !out_valid_q && rsta_n;
    in_ready = rsta_n && !ram_full && !rd_issue;
    wr_fire  = in_valid && in_ready;
    wea      = wr_fire;
    addra    = rd_issue ? rd_ptr_q : wr_ptr_q;
    dina     = in_data;
  end

  // Next-state computation for pointers, count and the output register.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    ram_cnt_d    = ram_cnt_q;
    rd_pending_d = rd_issue;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;

    if (wr_fire) begin
      wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
      ram_cnt_d = ram_cnt_q + CNT_W'(1);
    end
    if (rd_issue) begin
      rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
      ram_cnt_d = ram_cnt_q - CNT_W'(1);
    end

    // A pending read always lands in an empty output register, because a
    // read is only issued while out_valid is low.
    if (rd_pending_q) begin
      out_data_d  = douta;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ram_cnt_q    <= '0;
      rd_pending_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_cnt_q    <= ram_cnt_d;
      rd_pending_q <= rd_pending_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  // Status outputs derived from registered state.
  always_comb begin
    out_valid = out_valid_q;
    out_data  = out_data_q;
    occupancy = ram_cnt_q + CNT_W'(rd_pending_q) + CNT_W'(out_valid_q);
    full      = ram_full;
    empty     = (occupancy == '0);
  end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed self-checking bench for bram_fifo_ctrl with a behavioural
// 8x8 single-port RAM standing in for the Core Generator block.
module tb_bram_fifo_ctrl;

  logic       clka;
  logic       rsta_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [3:0] occupancy;
  logic       full;
  logic       empty;
  logic       wea;
  logic [2:0] addra;
  logic [7:0] dina;
  logic [7:0] douta;

  logic [7:0] mem [8];

  int total;
  int bad;
  int wr_total;

  bram_fifo_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
    .clka      (clka),
    .rsta_n    (rsta_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .douta     (douta)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Single-port RAM, registered read with one cycle latency.
  always @(posedge clka) begin
    if (wea) mem[addra] <= dina;
    douta <= mem[addra];
  end

  task automatic tick;
    @(posedge clka);
    #1;
  endtask

  task automatic test_reset;
    rsta_n    = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (wea !== 1'b0) begin bad++; $display("FAIL reset_wea cyc=%0d got=%b exp=0", i, wea); end
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      tick();
    end
    total++;
    if (wea !== 1'b0) begin bad++; $display("FAIL reset_wea_last got=%b exp=0", wea); end
    rsta_n   = 1'b1;
    in_valid = 1'b0;
    wr_total = 0;
    #1;
    total++;
    if (occupancy !== 4'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b exp=1", in_ready); end
    total++;
    if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++;
    if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    total++;
    if (addra !== 3'd0) begin bad++; $display("FAIL reset_addra got=%0d exp=0", addra); end
    tick();
  endtask

  task automatic test_single;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    out_ready = 1'b0;
    #1;
    total++;
    if (wea !== 1'b1 || addra !== 3'd0 || dina !== 8'hA5) begin
      bad++; $display("FAIL single_t_write got wea=%b addra=%0d dina=%h exp 1/0/a5", wea, addra, dina);
    end
    tick();
    wr_total++;
    in_valid = 1'b0;
    #1;
    total++;
    if (wea !== 1'b0 || addra !== 3'd0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL single_t1_read got wea=%b addra=%0d in_ready=%b exp 0/0/0", wea, addra, in_ready);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL single_t2_not_yet got=%b exp=0", out_valid); end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || occupancy !== 4'd1) begin
      bad++; $display("FAIL single_t3_out got valid=%b data=%h occ=%0d exp 1/a5/1", out_valid, out_data, occupancy);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
        bad++; $display("FAIL single_stall cyc=%0d got valid=%b data=%h exp 1/a5", i, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    total++;
    if (empty !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL single_pop got empty=%b valid=%b exp 1/0", empty, out_valid);
    end
    total++;
    if (out_data !== 8'hA5) begin bad++; $display("FAIL single_data_hold got=%h exp=a5", out_data); end
    tick();
  endtask

  task automatic test_fill;
    int acc;
    int n;
    acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h10 + acc);
      #1;
      if (in_ready) begin acc++; wr_total++; end
      tick();
    end
    in_valid = 1'b0;
    #1;
    total++;
    if (acc !== 9) begin bad++; $display("FAIL fill_accepted got=%0d exp=9", acc); end
    total++;
    if (full !== 1'b1 || occupancy !== 4'd9 || in_ready !== 1'b0) begin
      bad++; $display("FAIL fill_full got full=%b occ=%0d in_ready=%b exp 1/9/0", full, occupancy, in_ready);
    end
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 9; c++) begin
      #1;
      if (c == 0 || c == 1) begin
        total++;
        if (full !== 1'b1) begin bad++; $display("FAIL fill_full_hold cyc=%0d got=%b exp=1", c, full); end
      end
      if (c == 2) begin
        total++;
        if (full !== 1'b0) begin bad++; $display("FAIL fill_full_drop got=%b exp=0", full); end
      end
      if (out_valid) begin
        total++;
        if (out_data !== 8'(8'h10 + n)) begin
          bad++; $display("FAIL fill_order idx=%0d got=%h exp=%h", n, out_data, 8'(8'h10 + n));
        end
        n++;
      end
      tick();
    end
    out_ready = 1'b0;
    #1;
    total++;
    if (n !== 9 || empty !== 1'b1) begin
      bad++; $display("FAIL fill_drain got count=%0d empty=%b exp 9/1", n, empty);
    end
    tick();
  endtask

  task automatic test_wrap;
    int sent;
    int rx;
    sent = 0;
    rx   = 0;
    for (int c = 0; c < 400 && rx < 20; c++) begin
      in_valid  = (sent < 20);
      in_data   = 8'(sent);
      out_ready = ((c / 2) % 2) == 1;
      #1;
      if (in_valid && in_ready) begin
        total++;
        if (addra !== 3'(wr_total)) begin
          bad++; $display("FAIL wrap_wr_addr byte=%0d got=%0d exp=%0d", sent, addra, 3'(wr_total));
        end
        sent++;
        wr_total++;
      end
      if (out_valid && out_ready) begin
        total++;
        if (out_data !== 8'(rx)) begin
          bad++; $display("FAIL wrap_order idx=%0d got=%h exp=%h", rx, out_data, 8'(rx));
        end
        rx++;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    total++;
    if (rx !== 20 || empty !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL wrap_done got rx=%0d empty=%b valid=%b exp 20/1/0", rx, empty, out_valid);
    end
  endtask

  task automatic test_reset_mid;
    int acc;
    bit seen;
    acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 40 && acc < 6; c++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h50 + acc);
      #1;
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    total++;
    if (occupancy !== 4'd6 || out_valid !== 1'b1) begin
      bad++; $display("FAIL mid_setup got occ=%0d valid=%b exp 6/1", occupancy, out_valid);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    total++;
    if (occupancy !== 4'd5 || out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_pending got occ=%0d valid=%b exp 5/0", occupancy, out_valid);
    end
    rsta_n = 1'b0;
    tick();
    rsta_n   = 1'b1;
    wr_total = 0;
    #1;
    total++;
    if (occupancy !== 4'd0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
      bad++; $display("FAIL mid_cleared got occ=%0d valid=%b data=%h exp 0/0/00", occupancy, out_valid, out_data);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale cyc=%0d got=%b exp=0", i, out_valid); end
    end
    in_valid = 1'b1;
    in_data  = 8'h3C;
    #1;
    total++;
    if (wea !== 1'b1 || addra !== 3'd0) begin
      bad++; $display("FAIL mid_push got wea=%b addra=%0d exp 1/0", wea, addra);
    end
    tick();
    in_valid = 1'b0;
    wr_total++;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (out_valid) seen = 1'b1;
      else tick();
    end
    total++;
    if (!seen || out_data !== 8'h3C) begin
      bad++; $display("FAIL mid_first_out got seen=%b data=%h exp 1/3c", seen, out_data);
    end
  endtask

  task automatic test_concurrent;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    out_ready = 1'b1;
    #1;
    total++;
    if (occupancy !== 4'd1 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      bad++; $display("FAIL conc_setup got occ=%0d valid=%b in_ready=%b exp 1/1/1", occupancy, out_valid, in_ready);
    end
    total++;
    if (wea !== 1'b1) begin bad++; $display("FAIL conc_wea got=%b exp=1", wea); end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    total++;
    if (occupancy !== 4'd1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL conc_occ got occ=%0d valid=%b exp 1/0", occupancy, out_valid);
    end
    tick();
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h77) begin
      bad++; $display("FAIL conc_data got valid=%b data=%h exp 1/77", out_valid, out_data);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    wr_total = 0;
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_reset_mid();
    test_concurrent();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_fifo_ctrl.md
Name: bram_fifo_ctrl

Overview:
- Streaming FIFO controller that sits directly in front of the 8x8 single-port Core Generator block RAM (clka/wea/addra/dina/douta) and owns all of that RAM's ports.
- Accepts bytes on a valid/ready input, writes them into the RAM and reads them back in order.
- Presents the bytes on a valid/ready output with a one-entry output register.
- Arbitrates the single RAM port between writes and reads.

Parameters:
- DATA_W, 8: data width; must equal the RAM's dina/douta width.
- ADDR_W, 3: RAM address width. DEPTH = 2**ADDR_W is a derived localparam (8).

Ports:
- clka  in  1  clock; also the RAM clock.
- rsta_n  in  1  synchronous active-low reset.
- in_valid  in  1  producer has data.
- in_data  in  DATA_W  producer byte.
- in_ready  out  1  controller accepts in_data this cycle.
- out_valid  out  1  out_data holds a valid byte.
- out_data  out  DATA_W  oldest byte.
- out_ready  in  1  consumer takes out_data this cycle.
- occupancy  out  ADDR_W+1  total bytes held (RAM + in-flight + output register), 0..DEPTH+1.
- full  out  1  RAM holds DEPTH unread bytes.
- empty  out  1  occupancy == 0.
- wea  out  1  RAM write enable.
- addra  out  ADDR_W  RAM address.
- dina  out  DATA_W  RAM write data.
- douta  in  DATA_W  RAM read data; valid one clka cycle after its address is sampled.

Behaviour:
- State registers: wr_ptr, rd_ptr (ADDR_W, wrap DEPTH-1 -> 0), ram_cnt (0..DEPTH), rd_pending (1 bit), out_valid, out_data.
- Read issue (combinational, registered state only): rd_issue = (ram_cnt != 0) && !rd_pending && !out_valid && rsta_n.
  - No combinational path from out_ready or in_valid to in_ready.
- in_ready = rsta_n && (ram_cnt != DEPTH) && !rd_issue. Reads have priority over writes for the port.
- Write: when in_valid && in_ready: wea=1, addra=wr_ptr, dina=in_data. At the clock edge wr_ptr++ and ram_cnt++.
- Read: when rd_issue: wea=0, addra=rd_ptr. At the clock edge rd_ptr++, ram_cnt--, rd_pending<=1. The slot is free immediately after this edge.
- Idle port: wea=0, addra=wr_ptr, dina=in_data.
- Output register load: cycle after issue (rd_pending=1): at the edge out_data<=douta, out_valid<=1, rd_pending<=0.
- Pop: out_valid && out_ready clears out_valid at the edge. out_data holds its value; it is not cleared.
- out_data is stable while out_valid=1 and out_ready=0.
- Latency: a byte written in cycle t produces out_valid=1 in cycle t+3 if the controller is otherwise empty.
- Throughput: reads sustain one byte per 3 cycles; writes sustain one byte per cycle when no read is issuing.
- occupancy = ram_cnt + rd_pending + out_valid. Maximum is DEPTH+1 = 9 (8 in RAM + 1 in output register).
- full = (ram_cnt == DEPTH). empty = (occupancy == 0).
- Simultaneous events:
  - Write accept and pop in the same cycle are independent and both take effect.
  - Write and read issue in the same cycle are impossible by construction.
- Reset while rsta_n=0, sampled at the edge:
  - Clears wr_ptr, rd_ptr, ram_cnt, rd_pending, out_valid, and sets out_data to 0.
  - in_ready=0 and wea=0 combinationally throughout reset.
  - A pending read's douta is discarded.
  - RAM contents are not cleared.
- Values after reset: in_ready=1, out_valid=0, out_data=0, occupancy=0, full=0, empty=1, wea=0, addra=0.
- Out-of-range: in_valid while in_ready=0 is ignored, and in_data must not be written.

Decomposition:
- Shared package bram_fifo_pkg holds:
  - DATA_W/ADDR_W defaults;
  - the DEPTH derivation;
  - the read-latency constant RAM_RD_LAT = 1.
- No sub-module: the block is a single module.
- The bench instantiates bram_fifo_ctrl with the generated 8x8 RAM core wired to wea/addra/dina/douta.

Test Plan:
- Reset: rsta_n=0 for 3 cycles with in_valid=1 and in_data=0xFF -> wea=0 and in_ready=0 throughout; after release occupancy=0, empty=1, out_valid=0.
- Single byte: push 0xA5 at cycle t with out_ready=0 -> signals below; out_data holds across 5 stall cycles, and pop in t+8 gives empty=1.
  - t: wea=1, addra=0, dina=0xA5.
  - t+1: wea=0, addra=0, in_ready=0.
  - t+3: out_valid=1, out_data=0xA5, occupancy=1.
- Fill/full: out_ready=0, continuous in_valid with 0x10,0x11,... -> exactly 9 bytes accepted (0x10..0x18); then full=1, occupancy=9, in_ready=0. Then out_ready=1 -> 0x10..0x18 emerge in order, full drops after first read issue.
- Wrap-around: 20 bytes 0x00..0x13 with out_ready toggling every 2 cycles -> all 20 emerge in order, none lost or duplicated; addra wraps 7->0 for both pointers.
- Reset mid-operation: occupancy=5 with rd_pending=1, then rsta_n=0 for one cycle -> next cycle occupancy=0, out_valid=0, and the stale douta never appears. Then push 0x3C -> first output is 0x3C.
- Concurrent push/pop: steady state with out_valid=1, out_ready=1 and in_valid=1 on the same cycle -> both take effect; occupancy unchanged that cycle.
